// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Recovers pixel timing from a VGA sync stream clocked on the generator's own
// pixel clock. The block measures line length and frame height, locks after a
// run of consistent lines and frames, and then emits the pixel coordinates
// together with the colour that was sampled for that position.
//
// Pipeline: stage 1 registers the raw inputs and all decoding works on it.
// Stage 2 registers the pixel outputs from the counters' next values. As a
// result, pix_x/pix_y always equal hcnt/vcnt minus the active offsets in the
// cycle they are shown, and pix_rgb is the rgb_in sampled two clocks earlier.
module vga_sync_decoder #(
    parameter int H_TOTAL          = 800,
    parameter int H_SYNC_TO_ACTIVE = 144,
    parameter int H_ACTIVE         = 640,
    parameter int V_TOTAL          = 525,
    parameter int V_SYNC_TO_ACTIVE = 35,
    parameter int V_ACTIVE         = 480,
    parameter int LOCK_LINES       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [5:0] rgb_in,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [5:0] pix_rgb,
    output logic [9:0] line_len,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);

    // Timing constants, all carried at the 10-bit counter width.
    localparam logic [9:0] CNT_MAX_C  = 10'h3FF;
    localparam logic [9:0] H_TOTAL_C  = 10'(H_TOTAL);
    localparam logic [9:0] H_LOST_C   = 10'(H_TOTAL + 16);
    localparam logic [9:0] V_TOTAL_C  = 10'(V_TOTAL);
    localparam logic [9:0] H_ACT_LO_C = 10'(H_SYNC_TO_ACTIVE);
    localparam logic [9:0] H_ACT_HI_C = 10'(H_SYNC_TO_ACTIVE + H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LO_C = 10'(V_SYNC_TO_ACTIVE);
    localparam logic [9:0] V_ACT_HI_C = 10'(V_SYNC_TO_ACTIVE + V_ACTIVE - 1);
    localparam logic [9:0] LOCK_C     = 10'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Saturating increment: counters stick at full scale rather than wrap.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        logic [9:0] r;
        if (v == CNT_MAX_C) begin
            r = v;
        end else begin
            r = v + 10'd1;
        end
        return r;
    endfunction

    // Stage 1 input registers.
    logic       hs1_q, hs1_prev_q;
    logic       vs1_q, vs1_prev_q;
    logic [5:0] rgb1_q;

    // Counters and measurement state.
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       pend_q, pend_d;
    logic [9:0] line_len_q, line_len_d;

    // Lock FSM state and its registered outputs.
    state_e     state_q;
    logic [9:0] good_q, good_d;
    logic       vseen_q;
    logic       locked_q, locked_d;
    logic       frame_start_q;
    logic       sync_err_q;

    // Stage 2 pixel outputs.
    logic       pix_valid_q, pix_valid_d;
    logic [9:0] pix_x_q, pix_x_d;
    logic [9:0] pix_y_q, pix_y_d;
    logic [5:0] pix_rgb_q, pix_rgb_d;

    // Decoded events.
    logic       hs_fall_s, vs_fall_s, reload_s;
    logic [9:0] meas_len_s, frame_lines_s;
    logic       line_bad_s, frame_bad_s, h_lost_s, v_lost_s;
    logic       lock_exit_s, lock_enter_s;
    logic       h_in_s, v_in_s;

    // Stage 1: sample the raw sync and colour inputs; syncs idle high so a low
    // level present at reset release is decoded as a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs1_q      <= 1'b1;
            hs1_prev_q <= 1'b1;
            vs1_q      <= 1'b1;
            vs1_prev_q <= 1'b1;
            rgb1_q     <= 6'd0;
        end else begin
            hs1_q      <= hsync_in;
            hs1_prev_q <= hs1_q;
            vs1_q      <= vsync_in;
            vs1_prev_q <= vs1_q;
            rgb1_q     <= rgb_in;
        end
    end

    // Edge detection and the measurements that become valid at an hsync edge.
    always_comb begin
        hs_fall_s     = hs1_prev_q & ~hs1_q;
        vs_fall_s     = vs1_prev_q & ~vs1_q;
        reload_s      = hs_fall_s & (pend_q | vs_fall_s);
        meas_len_s    = sat_inc(hcnt_q);
        frame_lines_s = sat_inc(vcnt_q);
    end

    // Next-state logic for the horizontal/vertical counters and vsync pending.
    always_comb begin
        if (hs_fall_s) begin
            hcnt_d     = 10'd0;
            line_len_d = meas_len_s;
        end else begin
            hcnt_d     = sat_inc(hcnt_q);
            line_len_d = line_len_q;
        end

        if (reload_s) begin
            vcnt_d = 10'd0;
        end else if (hs_fall_s) begin
            vcnt_d = sat_inc(vcnt_q);
        end else begin
            vcnt_d = vcnt_q;
        end

        // A vsync edge waits for the next hsync edge (or the same one) to
        // mark the frame boundary.
        if (reload_s) begin
            pend_d = 1'b0;
        end else if (vs_fall_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q     <= 10'd0;
            vcnt_q     <= 10'd0;
            pend_q     <= 1'b0;
            line_len_q <= 10'd0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            pend_q     <= pend_d;
            line_len_q <= line_len_d;
        end
    end

    // Lock qualification: good-line run length, lock entry and loss conditions.
    always_comb begin
        if (hs_fall_s) begin
            if (meas_len_s == H_TOTAL_C) begin
                if (good_q >= LOCK_C) begin
                    good_d = LOCK_C;
                end else begin
                    good_d = good_q + 10'd1;
                end
            end else begin
                good_d = 10'd0;
            end
        end else begin
            good_d = good_q;
        end

        line_bad_s   = hs_fall_s & (meas_len_s != H_TOTAL_C);
        frame_bad_s  = reload_s & (frame_lines_s != V_TOTAL_C);
        h_lost_s     = (hcnt_q == H_LOST_C);
        v_lost_s     = (vcnt_q == V_TOTAL_C);
        lock_exit_s  = line_bad_s | frame_bad_s | h_lost_s | v_lost_s;
        lock_enter_s = reload_s & vseen_q & (frame_lines_s == V_TOTAL_C) &
                       (good_d == LOCK_C);

        // Whether the FSM will be in LOCKED after this edge.
        case (state_q)
            LOCKED:  locked_d = ~lock_exit_s;
            ACQ:     locked_d = lock_enter_s;
            default: locked_d = 1'b0;
        endcase
    end

    // Lock FSM with its registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            good_q        <= 10'd0;
            vseen_q       <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            sync_err_q    <= 1'b0;
            locked_q      <= locked_d;
            frame_start_q <= reload_s & locked_d;
            case (state_q)
                SEARCH: begin
                    if (hs_fall_s) begin
                        state_q <= ACQ;
                        good_q  <= 10'd0;
                        vseen_q <= 1'b0;
                    end
                end
                ACQ: begin
                    good_q <= good_d;
                    if (reload_s) begin
                        vseen_q <= 1'b1;
                    end
                    if (lock_enter_s) begin
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (lock_exit_s) begin
                        state_q    <= SEARCH;
                        sync_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SEARCH;
                    good_q  <= 10'd0;
                    vseen_q <= 1'b0;
                end
            endcase
        end
    end

    // Active-window decode on the counters' next values, so stage 2 lines up
    // with the colour sampled in stage 1.
    always_comb begin
        h_in_s      = (hcnt_d >= H_ACT_LO_C) && (hcnt_d <= H_ACT_HI_C);
        v_in_s      = (vcnt_d >= V_ACT_LO_C) && (vcnt_d <= V_ACT_HI_C);
        pix_valid_d = locked_d & h_in_s & v_in_s;
        if (pix_valid_d) begin
            pix_x_d   = hcnt_d - H_ACT_LO_C;
            pix_y_d   = vcnt_d - V_ACT_LO_C;
            pix_rgb_d = rgb1_q;
        end else begin
            pix_x_d   = 10'd0;
            pix_y_d   = 10'd0;
            pix_rgb_d = 6'd0;
        end
    end

    // Stage 2 pixel output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            pix_x_q     <= 10'd0;
            pix_y_q     <= 10'd0;
            pix_rgb_q   <= 6'd0;
        end else begin
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_rgb_q   <= pix_rgb_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign line_len    = line_len_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder. A scaled-down raster (64 x 20, hsync 8 clocks,
// vsync 2 lines, both syncs falling in the same clock) keeps each frame short.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

    localparam int HT  = 64;
    localparam int HSA = 16;
    localparam int HA  = 40;
    localparam int VT  = 20;
    localparam int VSA = 4;
    localparam int VA  = 12;
    localparam int LL  = 4;
    localparam int HSW = 8;
    localparam int VSW = 2;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [5:0] rgb_in = 6'd0;
    logic       pix_valid;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [5:0] pix_rgb;
    logic [9:0] line_len;
    logic       locked;
    logic       frame_start;
    logic       sync_err;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC_TO_ACTIVE(HSA), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC_TO_ACTIVE(VSA), .V_ACTIVE(VA),
        .LOCK_LINES(LL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .line_len(line_len), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         gx;
        int         gy;
        logic [5:0] rgb;
        logic       exp_valid;
        logic [9:0] exp_x;
        logic [9:0] exp_y;
        logic [5:0] exp_rgb;
    } probe_t;

    probe_t probes [8];

    int n_cmp = 0;
    int n_bad = 0;

    // Generator state
    int         gx = 30;
    int         gy = 10;
    int         short_gy = -1;
    bit         hs_hold = 1'b0;
    bit         pix_single = 1'b0;
    logic [5:0] rgb_drive = 6'd0;
    int         bench_reload = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    logic       hs_prev_drv = 1'b1;

    // Monitors
    int   err_cnt = 0, err_wide = 0, fs_cnt = 0, fs_wide = 0, fs_last = 0, fs_interval = 0;
    int   zero_viol = 0, unlocked_valid = 0, valid_cnt = 0, nz_cnt = 0, hit_cnt = 0;
    logic locked_prev = 1'b0, fs_prev = 1'b0, err_prev = 1'b0;
    int   rise_reload = -1, rise_gx = -1, rise_gy = -1;
    logic rise_fs = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One pixel clock: drive the raster position, clock, observe, advance.
    task automatic step();
        int len;
        hsync_in = (hs_hold || gx >= HSW) ? 1'b1 : 1'b0;
        vsync_in = (gy < VSW) ? 1'b0 : 1'b1;
        if (pix_single) rgb_in = (gx == HSA && gy == VSA) ? 6'h2D : 6'h00;
        else rgb_in = rgb_drive;
        if (gx == 0 && gy == 0 && !hs_hold) bench_reload++;
        @(posedge clk);
        #1;
        cyc++;
        if (!hsync_in && hs_prev_drv) last_fall_cyc = cyc;
        hs_prev_drv = hsync_in;
        if (sync_err) begin
            err_cnt++;
            if (err_prev) err_wide++;
        end
        if (frame_start) begin
            fs_cnt++;
            fs_interval = cyc - fs_last;
            fs_last = cyc;
            if (fs_prev) fs_wide++;
        end
        if (!pix_valid && (pix_x != 10'd0 || pix_y != 10'd0 || pix_rgb != 6'd0)) zero_viol++;
        if (pix_valid && !locked) unlocked_valid++;
        if (pix_valid) valid_cnt++;
        if (pix_rgb != 6'd0) nz_cnt++;
        if (pix_valid && pix_x == 10'd0 && pix_y == 10'd0 && pix_rgb == 6'h2D) hit_cnt++;
        if (locked && !locked_prev) begin
            rise_reload = bench_reload;
            rise_gx = gx;
            rise_gy = gy;
            rise_fs = frame_start;
        end
        err_prev = sync_err;
        fs_prev = frame_start;
        locked_prev = locked;
        len = (gy == short_gy) ? HT - 1 : HT;
        gx++;
        if (gx >= len) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end
    endtask

    // Step until the next drive position is (tx, ty).
    task automatic advance_to(input int tx, input int ty);
        int n = 0;
        while (!(gx == tx && gy == ty) && n < 3 * FRAME) begin
            step();
            n++;
        end
        chk("advance_to", (gx == tx && gy == ty), 1);
    endtask

    task automatic wait_lock(input int budget);
        int n = 0;
        while (locked !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("lock_reached", locked, 1);
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_outs_zero"},
                {pix_valid, pix_x, pix_y, pix_rgb, line_len, locked, frame_start, sync_err}, 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int base, e0, v0, fs0, nz0, hit0;

        probes[0] = '{30, 3,  6'h3F, 1'b0, 10'd0,  10'd0,  6'h00};
        probes[1] = '{14, 4,  6'h3F, 1'b0, 10'd0,  10'd0,  6'h00};
        probes[2] = '{16, 4,  6'h2D, 1'b1, 10'd0,  10'd0,  6'h2D};
        probes[3] = '{55, 4,  6'h11, 1'b1, 10'd39, 10'd0,  6'h11};
        probes[4] = '{57, 4,  6'h22, 1'b0, 10'd0,  10'd0,  6'h00};
        probes[5] = '{40, 10, 6'h07, 1'b1, 10'd24, 10'd6,  6'h07};
        probes[6] = '{16, 15, 6'h0A, 1'b1, 10'd0,  10'd11, 6'h0A};
        probes[7] = '{20, 16, 6'h15, 1'b0, 10'd0,  10'd0,  6'h00};

        // Power-up reset, stream starting mid-frame.
        reset_pulse("por");
        base = bench_reload;
        wait_lock(5 * FRAME);
        chk("first_lock_reload", rise_reload, base + 2);
        chk("first_lock_gx", rise_gx, 1);
        chk("first_lock_gy", rise_gy, 0);
        chk("first_lock_frame_start", rise_fs, 1);
        chk("line_len_clean", line_len, HT);

        // Steady locked run.
        fs0 = fs_cnt;
        repeat (2 * FRAME + 10) step();
        chk("steady_fs_count", fs_cnt - fs0, 2);
        chk("steady_fs_interval", fs_interval, FRAME);
        chk("steady_locked", locked, 1);
        chk("steady_no_err", err_cnt, 0);

        // Pixel position/colour probes.
        for (int i = 0; i < 8; i++) begin
            advance_to(probes[i].gx, probes[i].gy);
            rgb_drive = probes[i].rgb;
            step();
            rgb_drive = 6'd0;
            step();
            chk($sformatf("probe%0d_valid", i), pix_valid, probes[i].exp_valid);
            chk($sformatf("probe%0d_xy_rgb", i), {pix_x, pix_y, pix_rgb},
                {probes[i].exp_x, probes[i].exp_y, probes[i].exp_rgb});
        end

        // One frame with a single coloured pixel at the active origin.
        advance_to(0, 0);
        v0 = valid_cnt; nz0 = nz_cnt; hit0 = hit_cnt;
        pix_single = 1'b1;
        repeat (FRAME) step();
        pix_single = 1'b0;
        repeat (2) step();
        chk("frame_valid_count", valid_cnt - v0, HA * VA);
        chk("single_pixel_hit", hit_cnt - hit0, 1);
        chk("single_pixel_nonzero", nz_cnt - nz0, 1);

        // One short line while locked.
        advance_to(0, 5);
        short_gy = 5;
        advance_to(0, 6);
        short_gy = -1;
        step();
        step();
        chk("short_line_len", line_len, HT - 1);
        chk("short_sync_err", sync_err, 1);
        chk("short_unlocked", locked, 0);
        chk("short_pix_valid", pix_valid, 0);
        step();
        chk("short_err_pulse_end", sync_err, 0);
        base = bench_reload;
        wait_lock(5 * FRAME);
        chk("short_relock_reload", rise_reload, base + 2);
        chk("short_err_total", err_cnt, 1);

        // hsync held high while locked.
        advance_to(10, 3);
        hs_hold = 1'b1;
        begin
            int n = 0;
            while (sync_err !== 1'b1 && n < 200) begin
                step();
                n++;
            end
        end
        chk("hlost_err_delay", cyc - last_fall_cyc, HT + 16 + 2);
        chk("hlost_unlocked", locked, 0);
        v0 = valid_cnt;
        repeat (300) step();
        chk("hlost_no_valid", valid_cnt - v0, 0);
        hs_hold = 1'b0;
        wait_lock(5 * FRAME);
        chk("hlost_err_total", err_cnt, 2);

        // Reset mid-line while locked.
        advance_to(30, 7);
        e0 = err_cnt;
        reset_pulse("midrst");
        base = bench_reload;
        wait_lock(5 * FRAME);
        chk("midrst_relock_reload", rise_reload, base + 2);
        chk("midrst_no_err", err_cnt, e0);

        // Whole-run invariants.
        chk("err_single_cycle", err_wide, 0);
        chk("fs_single_cycle", fs_wide, 0);
        chk("zero_when_invalid", zero_viol, 0);
        chk("valid_only_locked", unlocked_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter H_TOTAL, default 800: expected clocks per line.
REQ-002 The block SHALL have parameter H_SYNC_TO_ACTIVE, default 144: clocks from the hsync falling edge to the first active pixel.
REQ-003 The block SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-004 The block SHALL have parameter V_TOTAL, default 525: expected lines per frame.
REQ-005 The block SHALL have parameter V_SYNC_TO_ACTIVE, default 35: lines from vcnt reload to the first active line.
REQ-006 The block SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-007 The block SHALL have parameter LOCK_LINES, default 4: consecutive good lines required before lock.

Ports (name, direction, width, meaning):
REQ-008 The block SHALL have port clk, input, 1: pixel clock, the same clock as the VGA generator.
REQ-009 The block SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-010 The block SHALL have port hsync_in, input, 1: horizontal sync, active low.
REQ-011 The block SHALL have port vsync_in, input, 1: vertical sync, active low.
REQ-012 The block SHALL have port rgb_in, input, 6: {r[1:0], g[1:0], b[1:0]}.
REQ-013 The block SHALL have port pix_valid, output, 1: the current output pixel is inside the active area and the block is locked.
REQ-014 The block SHALL have port pix_x, output, 10; port pix_y, output, 10; and port pix_rgb, output, 6.
REQ-015 The block SHALL have port line_len, output, 10: the most recently measured line length.
REQ-016 The block SHALL have port locked, output, 1; port frame_start, output, 1 (pulse); and port sync_err, output, 1 (pulse).

Function
REQ-017 The block SHALL register hsync_in, vsync_in and rgb_in once (stage 1). All decoding SHALL use the stage-1 values.
REQ-018 The block SHALL assert hs_fall when stage-1 hsync is 0 and its previous value was 1. vs_fall SHALL be defined likewise for vsync.
REQ-019 hcnt SHALL be 0 in the cycle after hs_fall, increment by 1 each cycle, and saturate at 1023.
REQ-020 On hs_fall, line_len SHALL be loaded with hcnt+1, saturated at 1023.
REQ-021 vs_fall SHALL set a pending flag. On the first hs_fall at or after vs_fall, including the same cycle, vcnt SHALL reload to 0 (a "reload event") and the pending flag SHALL clear.
REQ-022 On every other hs_fall, vcnt SHALL increment, saturating at 1023.
REQ-023 At each reload event, frame_lines SHALL be vcnt+1. This value is internal.
REQ-024 The FSM SHALL have the states SEARCH, ACQ and LOCKED.
REQ-025 SEARCH SHALL go to ACQ on hs_fall, with good_lines=0 and vseen=0.
REQ-026 In ACQ, on each hs_fall, good_lines SHALL increment (saturating at LOCK_LINES) if line_len equals H_TOTAL, and SHALL clear to 0 otherwise.
REQ-027 In ACQ, a reload event SHALL set vseen.
REQ-028 ACQ SHALL go to LOCKED on a reload event in which all of the following hold: vseen was already 1, frame_lines equals V_TOTAL, and good_lines equals LOCK_LINES.
REQ-029 LOCKED SHALL go to SEARCH on any of the following:
- hs_fall with line length not equal to H_TOTAL;
- a reload event with frame_lines not equal to V_TOTAL;
- hcnt reaching H_TOTAL+16 (hsync lost);
- vcnt reaching V_TOTAL without a reload (vsync lost).
On that transition, sync_err SHALL pulse high for exactly 1 cycle.
REQ-030 locked SHALL be 1 exactly while the state is LOCKED, registered.
REQ-031 frame_start SHALL pulse high for 1 cycle after every reload event that leaves the state LOCKED, including the event that enters LOCKED.
REQ-032 pix_valid SHALL be 1 when all of the following hold: locked=1, hcnt is in [H_SYNC_TO_ACTIVE, H_SYNC_TO_ACTIVE+H_ACTIVE-1], and vcnt is in [V_SYNC_TO_ACTIVE, V_SYNC_TO_ACTIVE+V_ACTIVE-1].
REQ-033 pix_x SHALL be hcnt-H_SYNC_TO_ACTIVE and pix_y SHALL be vcnt-V_SYNC_TO_ACTIVE.
REQ-034 pix_valid, pix_x and pix_y SHALL be registered, with stage 2 aligned to pix_rgb.
REQ-035 pix_rgb SHALL equal rgb_in from exactly 2 clocks earlier.
REQ-036 When pix_valid=0, pix_x, pix_y and pix_rgb SHALL be 0.
REQ-037 The decoder SHALL never drive inputs and SHALL have no other outputs. All arithmetic SHALL be 10-bit unsigned with no wrap (saturate only).

Reset
REQ-038 While rst_n=0 at a clk edge, the following SHALL all be 0: state=SEARCH, hcnt, vcnt, good_lines, vseen, the pending flag, line_len, pix_valid, pix_x, pix_y, pix_rgb, locked, frame_start and sync_err.
REQ-039 The stage-1 sync registers SHALL reset to 1 (idle high), so that a low sync level present at release is seen as a falling edge.
REQ-040 Reset asserted mid-frame SHALL override all events in that cycle. Lock SHALL then be re-acquired from SEARCH, with no sync_err pulse caused by the reset.

Verification
REQ-041 The bench SHALL drive a clean 800x525 stream (hsync low 96 clocks, vsync low 2 lines), starting mid-frame. Required response: locked rises at the second reload event after at least 4 good lines; line_len=800; frame_start pulses once per 420000 clocks; sync_err is never asserted.
REQ-042 The bench SHALL drive rgb_in=6'h2D at the clock 144 after the hsync fall on line 35 after reload, with all other pixels 0. Required response: exactly one output cycle with pix_valid=1, pix_x=0, pix_y=0 and pix_rgb=6'h2D.
REQ-043 While locked, the bench SHALL shorten one line to 799 clocks. Required response: at that hs_fall, line_len=799, sync_err pulses for 1 cycle, locked goes to 0 and pix_valid goes to 0. Relock SHALL occur after the following full frame.
REQ-044 While locked, the bench SHALL hold hsync_in high. Required response: sync_err when hcnt reaches 816, locked goes to 0, and no further pix_valid.
REQ-045 The bench SHALL make hsync and vsync fall in the same clock. Required response: vcnt reloads on that hs_fall, and the frame counts as V_TOTAL lines with no error.
REQ-046 The bench SHALL assert rst_n=0 for 3 clocks mid-line while locked. Required response: all outputs are 0 during reset, there is no sync_err, and locked reasserts at the second reload after release.
